// File: rtl/reg_wrap_if.sv
// Register-file port bundle: one write port (enable, index, data) and two
// read ports (index in, data out). The datapath drives it as master; the
// register file is the slave.
interface reg_wrap_if #(
   parameter int N = 32
);
   logic         Reg_write_in;
   logic [4:0]   Write_Register_1;
   logic [N-1:0] Write_Data;
   logic [4:0]   Read_Register_1;
   logic [4:0]   Read_Register_2;
   logic [N-1:0] Read_Data_1;
   logic [N-1:0] Read_Data_2;

   modport master (
      output Reg_write_in, Write_Register_1, Write_Data,
      output Read_Register_1, Read_Register_2,
      input  Read_Data_1, Read_Data_2
   );

   modport slave (
      input  Reg_write_in, Write_Register_1, Write_Data,
      input  Read_Register_1, Read_Register_2,
      output Read_Data_1, Read_Data_2
   );
endinterface : reg_wrap_if

// File: rtl/reg_wrap.sv
// 32 x N general-purpose register file: one synchronous write port, two
// combinational read ports, R0 hardwired to zero, asynchronous active-high
// clear of all registers.
// Optional build macro: REG_WRAP_BYPASS_EN -- when defined, a read port whose
// index matches an enabled, non-zero write index returns Write_Data in the
// same cycle (write-through forwarding). Undefined: reads return stored data.
module reg_wrap #(
   parameter int N = 32
) (
   input  logic       clk,
   input  logic       reset,
   reg_wrap_if.slave  bus
);

   logic [N-1:0] regs [0:31];
   logic         fwd_1;
   logic         fwd_2;

   // Write port: asynchronous clear, then at most one register per edge.
   // NOTE: the storage array carries an async clear because reset must zero
   // the architectural state immediately; that rules out a RAM macro here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            // NOTE: non-blocking assignments for all sequential state, so
            // every register samples pre-edge values regardless of order.
            regs[i] <= '0;
         end
      end else if (bus.Reg_write_in && (bus.Write_Register_1 != 5'd0)) begin
         regs[bus.Write_Register_1] <= bus.Write_Data;
      end
   end

`ifdef REG_WRAP_BYPASS_EN
   // Forwarding hits: an enabled write to the same index as a read port.
   assign fwd_1 = bus.Reg_write_in && (bus.Write_Register_1 == bus.Read_Register_1);
   assign fwd_2 = bus.Reg_write_in && (bus.Write_Register_1 == bus.Read_Register_2);
`else
   // No forwarding: reads always see the stored contents.
   assign fwd_1 = 1'b0;
   assign fwd_2 = 1'b0;
`endif

   // Read port 1: zero for R0 or under reset, else forwarded or stored data.
   always_comb begin
      // NOTE: default first so every path assigns the output; no latch.
      bus.Read_Data_1 = '0;
      if (!reset && (bus.Read_Register_1 != 5'd0)) begin
         if (fwd_1) bus.Read_Data_1 = bus.Write_Data;
         else       bus.Read_Data_1 = regs[bus.Read_Register_1];
      end
   end

   // Read port 2: same selection as port 1, independent index.
   always_comb begin
      bus.Read_Data_2 = '0;
      if (!reset && (bus.Read_Register_2 != 5'd0)) begin
         if (fwd_2) bus.Read_Data_2 = bus.Write_Data;
         else       bus.Read_Data_2 = regs[bus.Read_Register_2];
      end
   end

endmodule : reg_wrap

// File: tb/tb_reg_wrap.sv
// Self-checking bench for reg_wrap: directed scenarios plus a randomized run,
// all checked against an array model of the 32 architectural registers.
// Honours REG_WRAP_BYPASS_EN when the bench is built with it.
module tb_reg_wrap;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   logic [31:0] model [32];

   reg_wrap_if #(.N(32)) bus ();

   reg_wrap #(.N(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Expected read result for an index given the model and current inputs.
   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (reset || a == 5'd0) return 32'd0;
`ifdef REG_WRAP_BYPASS_EN
      if (bus.Reg_write_in && bus.Write_Register_1 == a) return bus.Write_Data;
`endif
      return model[a];
   endfunction

   // Architectural effect of one rising edge on the model.
   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
      end else if (bus.Reg_write_in && bus.Write_Register_1 != 5'd0) begin
         model[bus.Write_Register_1] = bus.Write_Data;
      end
   endtask

   // Drive one write at the falling edge and let it take effect.
   task automatic do_write(input logic we, input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.Reg_write_in     = we;
      bus.Write_Register_1 = a;
      bus.Write_Data       = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.Reg_write_in = 1'b0;
      bus.Write_Register_1 = 5'd0;
      bus.Write_Data = 32'd0;
      bus.Read_Register_1 = 5'd0;
      bus.Read_Register_2 = 5'd0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      #2;
      for (int i = 0; i < 32; i++) begin
         bus.Read_Register_1 = 5'(i);
         bus.Read_Register_2 = 5'(31 - i);
         #1;
         vectors += 2;
         if (bus.Read_Data_1 !== 32'd0) begin
            $display("FAIL reset_rd1 idx=%0d got=%h exp=0", i, bus.Read_Data_1);
            miscompares++;
         end
         if (bus.Read_Data_2 !== 32'd0) begin
            $display("FAIL reset_rd2 idx=%0d got=%h exp=0", 31 - i, bus.Read_Data_2);
            miscompares++;
         end
      end
      // Write attempt while reset is held must be ignored.
      do_write(1'b1, 5'd5, 32'hFFFF_FFFF);
      bus.Read_Register_1 = 5'd5;
      #1;
      vectors++;
      if (bus.Read_Data_1 !== 32'd0) begin
         $display("FAIL reset_write_ignored got=%h exp=0", bus.Read_Data_1);
         miscompares++;
      end
      // Release reset mid-cycle; R5 must still be clear afterwards.
      @(negedge clk);
      bus.Reg_write_in = 1'b0;
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (bus.Read_Data_1 !== 32'd0) begin
         $display("FAIL reset_release_r5 got=%h exp=0", bus.Read_Data_1);
         miscompares++;
      end
   endtask

   task automatic test_sequential();
      logic [4:0]  wa [4] = '{5'd2, 5'd4, 5'd25, 5'd31};
      logic [31:0] wd [4] = '{32'd15, 32'd21, 32'd8, 32'd76};
      logic [4:0]  r2 [4] = '{5'd3, 5'd5, 5'd26, 5'd30};
      for (int i = 0; i < 4; i++) do_write(1'b1, wa[i], wd[i]);
      @(negedge clk);
      bus.Reg_write_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.Read_Register_1 = wa[i];
         bus.Read_Register_2 = r2[i];
         #1;
         vectors += 2;
         if (bus.Read_Data_1 !== wd[i]) begin
            $display("FAIL seq_rd1 idx=%0d got=%0d exp=%0d", wa[i], bus.Read_Data_1, wd[i]);
            miscompares++;
         end
         if (bus.Read_Data_2 !== 32'd0) begin
            $display("FAIL seq_rd2 idx=%0d got=%0d exp=0", r2[i], bus.Read_Data_2);
            miscompares++;
         end
      end
   endtask

   task automatic test_zero_reg();
      do_write(1'b1, 5'd0, 32'd4);
      @(negedge clk);
      bus.Reg_write_in = 1'b0;
      bus.Read_Register_1 = 5'd0;
      bus.Read_Register_2 = 5'd0;
      #1;
      vectors += 2;
      if (bus.Read_Data_1 !== 32'd0 || bus.Read_Data_2 !== 32'd0) begin
         $display("FAIL zero_reg got=%h/%h exp=0/0", bus.Read_Data_1, bus.Read_Data_2);
         miscompares++;
      end
   endtask

   task automatic test_write_disable();
      bus.Read_Register_1 = 5'd2;
      bus.Read_Register_2 = 5'd2;
      for (int i = 0; i < 4; i++) begin
         do_write(1'b0, 5'd2, 32'd99);
         vectors += 2;
         if (bus.Read_Data_1 !== 32'd15 || bus.Read_Data_2 !== 32'd15) begin
            $display("FAIL write_disable got=%0d/%0d exp=15/15", bus.Read_Data_1, bus.Read_Data_2);
            miscompares++;
         end
      end
   endtask

   task automatic test_read_during_write();
      @(negedge clk);
      bus.Read_Register_1  = 5'd4;
      bus.Read_Register_2  = 5'd4;
      bus.Reg_write_in     = 1'b1;
      bus.Write_Register_1 = 5'd4;
      bus.Write_Data       = 32'd33;
      #1;
      vectors++;
`ifdef REG_WRAP_BYPASS_EN
      if (bus.Read_Data_1 !== 32'd33) begin
         $display("FAIL rdw_before got=%0d exp=33", bus.Read_Data_1);
         miscompares++;
      end
`else
      if (bus.Read_Data_1 !== 32'd21) begin
         $display("FAIL rdw_before got=%0d exp=21", bus.Read_Data_1);
         miscompares++;
      end
`endif
      @(posedge clk);
      model_edge();
      #1;
      vectors++;
      if (bus.Read_Data_2 !== 32'd33) begin
         $display("FAIL rdw_after got=%0d exp=33", bus.Read_Data_2);
         miscompares++;
      end
      @(negedge clk);
      bus.Reg_write_in = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.Read_Register_1 = 5'd31;
      #1;
      vectors++;
      if (bus.Read_Data_1 !== 32'd76) begin
         $display("FAIL async_pre got=%0d exp=76", bus.Read_Data_1);
         miscompares++;
      end
      // Pulse reset well before the next rising edge.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      #1;
      vectors++;
      if (bus.Read_Data_1 !== 32'd0) begin
         $display("FAIL async_drop got=%0d exp=0", bus.Read_Data_1);
         miscompares++;
      end
      // First write after release lands on the next edge.
      do_write(1'b1, 5'd31, 32'hA5A5_0001);
      vectors++;
      if (bus.Read_Data_1 !== 32'hA5A5_0001) begin
         $display("FAIL async_first_write got=%h exp=a5a50001", bus.Read_Data_1);
         miscompares++;
      end
      @(negedge clk);
      bus.Reg_write_in = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] e1, e2;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         bus.Reg_write_in     = ($urandom_range(0, 3) != 0);
         bus.Write_Register_1 = 5'($urandom_range(0, 31));
         bus.Write_Data       = $urandom;
         bus.Read_Register_1  = ($urandom_range(0, 3) == 0) ? bus.Write_Register_1
                                                            : 5'($urandom_range(0, 31));
         bus.Read_Register_2  = 5'($urandom_range(0, 31));
         for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
               @(posedge clk);
               model_edge();
            end
            #1;
            e1 = exp_read(bus.Read_Register_1);
            e2 = exp_read(bus.Read_Register_2);
            vectors += 2;
            if (bus.Read_Data_1 !== e1) begin
               $display("FAIL rand_rd1 n=%0d ph=%0d idx=%0d got=%h exp=%h",
                        n, ph, bus.Read_Register_1, bus.Read_Data_1, e1);
               miscompares++;
            end
            if (bus.Read_Data_2 !== e2) begin
               $display("FAIL rand_rd2 n=%0d ph=%0d idx=%0d got=%h exp=%h",
                        n, ph, bus.Read_Register_2, bus.Read_Data_2, e2);
               miscompares++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_zero_reg();
      test_write_disable();
      test_read_during_write();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_reg_wrap

// File: doc/reg_wrap.md
Name: reg_wrap

Overview:
- 32-entry, N-bit general-purpose register file wrapper for the processor datapath: one synchronous write port, two combinational read ports.
- Internally it decodes the write address, holds 32 registers, and feeds two 32:1 read multiplexers.
- Register 0 is hardwired to zero (MIPS convention).
- Sits between the instruction decode stage (read addresses) and the writeback stage (write address and data).

Parameters:
- N, 32, data width of every register, of Write_Data, and of both read ports.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge
- reset  input  1  asynchronous, active-high; clears all registers
- Reg_write_in  input  1  write enable; any nonzero level enables the write
- Write_Register_1  input  5  destination register index for the write
- Read_Register_1  input  5  source index, read port 1
- Read_Register_2  input  5  source index, read port 2
- Write_Data  input  N  data to be written
- Read_Data_1  output  N  contents of register Read_Register_1
- Read_Data_2  output  N  contents of register Read_Register_2

Behaviour:
- Storage: registers R0..R31, each N bits.
- Reset:
  - reset=1 asynchronously forces R1..R31 to 0 immediately, independent of clk.
  - While reset is held, writes are ignored and both read outputs show 0.
  - Deasserting reset mid-cycle: the first write takes effect on the next rising clk edge.
- Write:
  - On rising clk with reset=0 and Reg_write_in=1, R[Write_Register_1] <= Write_Data.
  - One write per cycle; takes effect at that edge.
  - If Reg_write_in=0, no register changes.
- R0: writes with Write_Register_1=0 are discarded; R0 always reads 0.
- Read:
  - Purely combinational, zero latency. Read_Data_1 = R[Read_Register_1]; Read_Data_2 = R[Read_Register_2].
  - Both ports may address the same register, giving identical outputs.
  - Outputs change only when the addressed register or the address changes.
- Read-during-write to the same index (default build): the read returns the old value until the clock edge, then the new value.
- All 5-bit indices are valid; there are no out-of-range cases.

Optional Feature:
- Macro: REG_WRAP_BYPASS_EN.
- Defined: write-through forwarding. If Reg_write_in=1, reset=0, Write_Register_1!=0 and a read index equals Write_Register_1, that read port outputs Write_Data combinationally in the same cycle. This applies independently to each port, and R0 still reads 0.
- Undefined: no forwarding; reads always return stored contents, as described under Behaviour.

Test Plan:
- Reset: hold reset=1, read indices 0..31 on both ports -> all outputs 0. Attempt a write of 0xFFFF_FFFF to R5 during reset -> R5 stays 0.
- Sequential writes: Reg_write_in=1; write R2=15, R4=21, R25=8, R31=76 on successive edges. Then read (R1 port, R2 port) pairs (2,3), (4,5), (25,26), (31,30) -> (15,0), (21,0), (8,0), (76,0).
- Zero register: write 4 to R0 with Reg_write_in=1 -> both ports reading index 0 return 0.
- Write disable: after R2=15, set Reg_write_in=0 and present Write_Register_1=2, Write_Data=99 for several edges -> R2 still reads 15.
- Async reset mid-operation: with R31=76 loaded, pulse reset=1 between clock edges -> Read_Data_1 at index 31 drops to 0 before the next edge.
- Same-cycle read/write on R4 (old value 21, Write_Data=33):
  - Without REG_WRAP_BYPASS_EN -> reads 21 before the edge, 33 after.
  - With REG_WRAP_BYPASS_EN -> reads 33 immediately.
